// File: rtl/obstacle_pkg.sv
// Shared types and constants for the obstacle spawn scheduler.
// Gap values expand a random nibble with forced-one low bits.
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    COUNT = 2'd2,
    REQ   = 2'd3
  } state_t;

  localparam int RND_W    = 4;
  localparam int LOW_ONES = 4;
  localparam int GAP_W    = RND_W + LOW_ONES;
  localparam int GAP_MIN  = 15;
  localparam int GAP_MAX  = 255;

  function automatic logic [GAP_W-1:0] gap_from_rnd(
    input logic [RND_W-1:0] r
  );
    return {r, {LOW_ONES{1'b1}}};
  endfunction

endpackage

// File: rtl/gap_down_counter.sv
// Loadable frame-gap down-counter with enable, sync clear and
// a flag marking the last frame before expiry.
module gap_down_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         en,
  output logic [W-1:0] cnt,
  output logic         is_one
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = load_val;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt    = cnt_q;
  assign is_one = (cnt_q == W'(1));

endmodule

// File: rtl/obstacle_spawn_scheduler.sv
// Counts a random frame gap down, then requests an obstacle spawn
// over a valid/ready handshake while the game is running.
module obstacle_spawn_scheduler
  import obstacle_pkg::*;
#(
  parameter int RND_W    = obstacle_pkg::RND_W,
  parameter int LOW_ONES = obstacle_pkg::LOW_ONES,
  parameter int GAP_W    = RND_W + LOW_ONES,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic             frame_tick,
  input  logic [RND_W-1:0] rnd,
  output logic             spawn_valid,
  input  logic             spawn_ready,
  output logic [1:0]       spawn_kind,
  output logic [GAP_W-1:0] gap_remaining,
  output logic [CNT_W-1:0] spawn_count
);

  state_t     state_q;
  state_t     state_d;
  logic       valid_q;
  logic       valid_d;
  logic [1:0] kind_q;
  logic [1:0] kind_d;

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  logic             cnt_clr;
  logic             cnt_load;
  logic             cnt_en;
  logic             gap_is_one;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_load;
  logic             xfer;

  assign gap_load = {rnd, {LOW_ONES{1'b1}}};
  assign xfer     = valid_q & spawn_ready;

  gap_down_counter #(
    .W (GAP_W)
  ) u_gap (
    .clk      (clk),
    .reset    (reset),
    .clr      (cnt_clr),
    .load     (cnt_load),
    .load_val (gap_load),
    .en       (cnt_en),
    .cnt      (gap_q),
    .is_one   (gap_is_one)
  );

  // A handshake is counted even when run drops in the same cycle.
  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    count_d  = count_q;
    cnt_clr  = 1'b0;
    cnt_load = 1'b0;
    cnt_en   = 1'b0;
    if (xfer) begin
      count_d = count_q + 1'b1;
    end
    case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (run) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (!run) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else begin
          cnt_load = 1'b1;
          kind_d   = rnd[1:0];
          state_d  = COUNT;
        end
      end
      COUNT: begin
        if (!run) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (frame_tick) begin
          cnt_en = 1'b1;
          if (gap_is_one) begin
            state_d = REQ;
          end
        end
      end
      REQ: begin
        if (!run) begin
          state_d = IDLE;
          cnt_clr = 1'b1;
        end else if (xfer) begin
          state_d = LOAD;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_clr = 1'b1;
      end
    endcase
    valid_d = (state_d == REQ);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      valid_q <= 1'b0;
      kind_q  <= 2'd0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      kind_q  <= kind_d;
      count_q <= count_d;
    end
  end

  assign spawn_valid   = valid_q;
  assign spawn_kind    = kind_q;
  assign gap_remaining = gap_q;
  assign spawn_count   = count_q;

endmodule

// File: doc/obstacle_spawn_scheduler.md
Name: obstacle_spawn_scheduler

Overview:
- Consumer side of the 4-bit obstacle LFSR: samples the random nibble, expands it to a frame gap of 15..255 frames, and counts frame ticks down to zero.
- At zero, issues a spawn request to the obstacle slot manager over a valid/ready handshake.
- Sits between the LFSR (q7..q4 bundled as rnd) and the obstacle renderer/slot logic.
- Runs only while the game is active.

Parameters:
- RND_W, 4, width of random input (LFSR bits q7..q4).
- LOW_ONES, 4, number of forced-one LSBs appended below rnd; gap = {rnd, LOW_ONES'b1...1}.
- GAP_W, RND_W+LOW_ONES (8), gap counter width.
- CNT_W, 8, width of spawn_count.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- run  in  1  game active; low aborts scheduling.
- frame_tick  in  1  one-cycle pulse per video frame.
- rnd  in  RND_W  random nibble {q7,q6,q5,q4} from LFSR.
- spawn_valid  out  1  spawn request pending.
- spawn_ready  in  1  slot manager accepts request.
- spawn_kind  out  2  obstacle type, rnd[1:0] captured at LOAD.
- gap_remaining  out  GAP_W  frames left before request.
- spawn_count  out  CNT_W  completed handshakes, wraps 255->0.

Behaviour:
- Reset (async, immediate): state IDLE; spawn_valid 0; spawn_kind 0; gap_remaining 0; spawn_count 0.
- All outputs are registered. spawn_valid = (state==REQ), Moore.
- IDLE: gap_remaining held 0. If run=1, go to LOAD next cycle.
- LOAD (exactly 1 cycle):
  - gap_remaining <= {rnd, all-ones}.
  - spawn_kind <= rnd[1:0].
  - Go to COUNT.
  - A frame_tick during LOAD is ignored.
- rnd=0 is legal (LFSR reset state, locks at 0000) and gives gap 15. rnd=4'hF gives 255. Zero gap is impossible.
- COUNT:
  - Each frame_tick decrements gap_remaining by 1.
  - On the tick where gap_remaining==1, it becomes 0 and the state goes to REQ.
  - So spawn_valid rises on the cycle after the G-th frame_tick following LOAD.
- REQ:
  - spawn_valid=1. spawn_kind and gap_remaining(=0) are held stable.
  - frame_ticks are ignored; no gap accumulates during backpressure.
  - Cycle with spawn_ready=1: transfer completes. spawn_count += 1 (modulo 2^CNT_W). Next state LOAD.
  - Back-to-back gaps therefore cost 1 LOAD cycle.
- spawn_valid is never withdrawn without a transfer, except via run=0 or reset.
- run=0 in any non-IDLE state: next state IDLE; spawn_valid falls next cycle; gap_remaining <= 0.
- Priority of run=0 versus transfer: if run=0 and spawn_valid & spawn_ready in the same cycle, the transfer counts (spawn_count increments), then IDLE.
- run=1 and frame_tick in the same cycle in IDLE: the tick is not counted.
- Reset mid-REQ or mid-COUNT: all state clears at once. No spawn is counted and there is no residual valid.
- spawn_ready in a non-REQ state has no effect.

Decomposition:
- Package obstacle_pkg:
  - state enum {IDLE, LOAD, COUNT, REQ}.
  - RND_W, LOW_ONES, GAP_W constants.
  - GAP_MIN=15 and GAP_MAX=255 constants for benches.
  - Function gap_from_rnd(rnd).
- Sub-module gap_down_counter: loadable GAP_W down-counter with enable (frame_tick), synchronous clear, and an is_one flag. The FSM and handshake live in the top.

Test Plan:
- Reset, run=1, rnd=4'h0, frame_tick every 4 cycles -> LOAD captures gap 15, kind 0. spawn_valid rises the cycle after the 15th tick. gap_remaining reads 0.
- rnd=4'hF, ready tied 1 -> gap 255, kind 3. spawn_count goes 0->1 on handshake. Next LOAD follows 1 cycle later with fresh rnd.
- Backpressure: in REQ hold spawn_ready=0 for 6 cycles with 2 frame_ticks -> valid stays 1, kind stable, count unchanged, gap stays 0. Raising ready -> count+1, then LOAD.
- run drops at gap_remaining=37 -> next cycle IDLE, gap 0, no valid. run re-raised -> LOAD with new rnd. Separately, run=0 with valid&ready in the same cycle -> count increments, then IDLE.
- Assert reset asynchronously mid-REQ (between clock edges) -> spawn_valid 0 immediately, spawn_count 0, state IDLE.
- 256 back-to-back spawns with rnd=0 and ready=1 -> spawn_count wraps 255->0.
